// File: rtl/tx_srrc_interp_if.sv
// Symbol/sample bus of the SRRC transmit interpolator.
// master = symbol source and sample sink, slave = the interpolator.
interface tx_srrc_interp_if;
   logic [1:0]         sym_in;
   logic               sym_valid;
   logic               sym_ready;
   logic signed [17:0] y;
   logic               y_valid;
   logic               underrun;

   modport master (
      output sym_in, sym_valid,
      input  sym_ready, y, y_valid, underrun
   );

   modport slave (
      input  sym_in, sym_valid,
      output sym_ready, y, y_valid, underrun
   );
endinterface

// File: rtl/tx_srrc_interp.sv
// tx_srrc_interp: 16QAM single-rail SRRC pulse shaper, 4x interpolation.
// Polyphase form: 8-symbol shift register, 4-phase counter, 31-tap
// symmetric SRRC (h[31] = 0). One 18-bit 1s17 sample per enabled clock.
// Optional feature: define TX_SRRC_UNDERRUN_CNT_EN to add the saturating
// 16-bit underrun_cnt output counting zero-insertion events.
module tx_srrc_interp #(
   parameter int LEVEL_A   = 8192,
   parameter int OUT_SHIFT = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   tx_srrc_interp_if.slave    bus
`ifdef TX_SRRC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]        underrun_cnt
`endif
);

   // Phase 3 is the slot in which a new symbol enters the shift register.
   typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_e;

   localparam logic signed [17:0] LVL_1   = 18'(LEVEL_A);
   localparam logic signed [17:0] LVL_3   = 18'(3 * LEVEL_A);
   localparam logic signed [39:0] SAT_MAX = 40'sd131071;
   localparam logic signed [39:0] SAT_MIN = -40'sd131072;

   // Gray symbol to amplitude level.
   function automatic logic signed [17:0] map_level(input logic [1:0] s);
      case (s)
         2'b00:   map_level = -LVL_3;
         2'b01:   map_level = -LVL_1;
         2'b11:   map_level = LVL_1;
         default: map_level = LVL_3;
      endcase
   endfunction

   // Full tap h[idx], folded onto the half table b[0..15]; h[31] is zero.
   function automatic logic signed [17:0] tap(input logic [4:0] idx);
      logic [3:0] m;
      m   = (idx <= 5'd15) ? idx[3:0] : 4'(5'd30 - idx);
      tap = '0;
      if (idx != 5'd31) begin
         case (m)
            4'd7:    tap = 18'sd1208;
            4'd8:    tap = -18'sd1252;
            4'd9:    tap = -18'sd3878;
            4'd10:   tap = -18'sd4525;
            4'd11:   tap = -18'sd1463;
            4'd12:   tap = 18'sd5416;
            4'd13:   tap = 18'sd14158;
            4'd14:   tap = 18'sd21475;
            4'd15:   tap = 18'sd24324;
            default: tap = '0;
         endcase
      end
   endfunction

   phase_e             phase_q, phase_d;
   logic signed [17:0] sym_q [8];
   logic signed [17:0] sym0_d;
   logic signed [17:0] y_q, y_d;
   logic               y_valid_q;
   logic               underrun_q, underrun_d;
   logic               take, starve;
   logic signed [35:0] prod [8];
   logic signed [39:0] acc, t;

   assign bus.sym_ready = enable && (phase_q == PH3);
   assign take          = bus.sym_ready && bus.sym_valid;
   assign starve        = bus.sym_ready && !bus.sym_valid;

   assign bus.y         = y_q;
   assign bus.y_valid   = y_valid_q;
   assign bus.underrun  = underrun_q;

   // Phase next-state: one step per enabled clock, 3 wraps to 0.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      phase_d = phase_q;
      if (enable) begin
         case (phase_q)
            PH0:     phase_d = PH1;
            PH1:     phase_d = PH2;
            PH2:     phase_d = PH3;
            default: phase_d = PH0;
         endcase
      end
   end

   // Phase state register; reset lands in phase 3 so the first enabled cycle requests a symbol.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
      if (!reset_n) phase_q <= PH3;
      else          phase_q <= phase_d;
   end

   // Polyphase dot product over the pre-edge register contents, then shift and saturate.
   always_comb begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
         prod[k] = 36'(sym_q[k]) * 36'(tap({3'(k), phase_q}));
         acc     = acc + {{4{prod[k][35]}}, prod[k]};
      end
      t = acc >>> OUT_SHIFT;
      if (t > SAT_MAX)      y_d = 18'sd131071;
      else if (t < SAT_MIN) y_d = -18'sd131072;
      else                  y_d = t[17:0];
      sym0_d     = take ? map_level(bus.sym_in) : '0;
      underrun_d = underrun_q | starve;
   end

   // Symbol shift register, output sample and sticky underrun; only y_valid moves while stalled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: the eight symbol slots are cleared on reset because a reset must discard in-flight symbols.
         for (int k = 0; k < 8; k++) sym_q[k] <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else if (enable) begin
         if (phase_q == PH3) begin
            for (int k = 7; k > 0; k--) sym_q[k] <= sym_q[k-1];
            sym_q[0] <= sym0_d;
         end
         y_q        <= y_d;
         y_valid_q  <= 1'b1;
         underrun_q <= underrun_d;
      end else begin
         y_valid_q  <= 1'b0;
      end
   end

`ifdef TX_SRRC_UNDERRUN_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of zero-insertion events (starve only fires while enabled).
   always_comb begin
      cnt_d = cnt_q;
      if (starve && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   // Underrun counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tx_srrc_interp.sv
// Testbench for tx_srrc_interp. Two instances share clock, reset and enable:
// dut_a uses default parameters, dut_b (LEVEL_A=43690, OUT_SHIFT=14) is fed
// a constant always-valid symbol to drive the output into saturation.
// The reference model is a superposition of symbol impulse responses indexed
// by enabled-clock count; expectations go into per-DUT queues and a monitor
// pops them whenever y_valid is high.
module tb_tx_srrc_interp;
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic enable  = 1'b0;

   always #5 clk = ~clk;

   tx_srrc_interp_if bus_a ();
   tx_srrc_interp_if bus_b ();

`ifdef TX_SRRC_UNDERRUN_CNT_EN
   logic [15:0] cnt_a, cnt_b;
`endif

   tx_srrc_interp #(.LEVEL_A(8192), .OUT_SHIFT(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus_a)
`ifdef TX_SRRC_UNDERRUN_CNT_EN
      , .underrun_cnt(cnt_a)
`endif
   );

   tx_srrc_interp #(.LEVEL_A(43690), .OUT_SHIFT(14)) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus_b)
`ifdef TX_SRRC_UNDERRUN_CNT_EN
      , .underrun_cnt(cnt_b)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int B_TAB [16] = '{0, 0, 0, 0, 0, 0, 0, 1208, -1252, -3878, -4525, -1463, 5416, 14158, 21475, 24324};
   int     lvl [2] = '{8192, 43690};
   int     shf [2] = '{16, 14};
   longint ins [2][4096];   // level inserted at each enabled edge since reset (0 if none)
   int     e_cnt [2];
   bit     und [2];
   int     ucnt [2];
   longint last_y [2];

   typedef struct packed {
      logic signed [17:0] y;
      logic               und;
      logic [15:0]        cnt;
   } exp_t;

   exp_t q_a [$];
   exp_t q_b [$];
   exp_t mon_a, mon_b;

   int   sat_hi = 0;
   int   sat_lo = 0;
   logic rdy_seen_a;
   logic signed [17:0] y_hist [40];

   function automatic longint coef(input int n);
      if (n <= 15) return longint'(B_TAB[n]);
      if (n <= 30) return longint'(B_TAB[30-n]);
      return 0;
   endfunction

   function automatic longint level_of(input int d, input logic [1:0] s);
      case (s)
         2'b00:   return -3 * longint'(lvl[d]);
         2'b01:   return -longint'(lvl[d]);
         2'b11:   return longint'(lvl[d]);
         default: return 3 * longint'(lvl[d]);
      endcase
   endfunction

   // Sample produced at enabled edge e_cnt[d]: sum of earlier insertions times the impulse response.
   function automatic longint ref_y(input int d);
      longint acc = 0;
      int     idx;
      for (int n = 0; n < 32; n++) begin
         idx = e_cnt[d] - 1 - n;
         if (idx >= 0) acc += ins[d][idx] * coef(n);
      end
      acc = acc >>> shf[d];
      if (acc > 131071)  acc = 131071;
      if (acc < -131072) acc = -131072;
      return acc;
   endfunction

   task automatic predict(input int d, input bit va, input logic [1:0] s);
      bit   rdy;
      exp_t ex;
      if (!reset_n) begin
         e_cnt[d] = 0; und[d] = 1'b0; ucnt[d] = 0; last_y[d] = 0;
         return;
      end
      if (!enable) return;
      if (e_cnt[d] >= 4096) begin
         $display("FAIL model_depth: got edge %0d, want below %0d", e_cnt[d], 4096);
         $fatal(1, "model depth exceeded");
      end
      rdy = (e_cnt[d] % 4 == 0);
      ins[d][e_cnt[d]] = (rdy && va) ? level_of(d, s) : 64'sd0;
      if (rdy && !va) begin
         und[d] = 1'b1;
         if (ucnt[d] < 65535) ucnt[d]++;
      end
      last_y[d] = ref_y(d);
      e_cnt[d]++;
      ex.y   = 18'(last_y[d]);
      ex.und = und[d];
      ex.cnt = 16'(ucnt[d]);
      if (d == 0) q_a.push_back(ex);
      else        q_b.push_back(ex);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (bus_a.y_valid === 1'b1) begin
         if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
         else begin
            mon_a = q_a.pop_front();
            check("a_y", $signed(bus_a.y), $signed(mon_a.y));
            check("a_underrun", bus_a.underrun, mon_a.und);
`ifdef TX_SRRC_UNDERRUN_CNT_EN
            check("a_underrun_cnt", cnt_a, mon_a.cnt);
`endif
         end
      end
      if (bus_b.y_valid === 1'b1) begin
         if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
         else begin
            mon_b = q_b.pop_front();
            check("b_y", $signed(bus_b.y), $signed(mon_b.y));
            check("b_underrun", bus_b.underrun, mon_b.und);
            if (bus_b.y == 18'sd131071)  sat_hi++;
            if (bus_b.y == -18'sd131072) sat_lo++;
         end
      end
   end

   // ---------------- stimulus ----------------
   // One clock: drive at negedge, check ready, predict, then check stall/reset state after the edge.
   task automatic step(input bit rst, input bit en, input bit va, input logic [1:0] sa, input logic [1:0] sb);
      @(negedge clk);
      reset_n         = !rst;
      enable          = en;
      bus_a.sym_valid = va;
      bus_a.sym_in    = sa;
      bus_b.sym_valid = 1'b1;
      bus_b.sym_in    = sb;
      #1;
      rdy_seen_a = bus_a.sym_ready;
      if (reset_n) begin
         check("a_sym_ready", bus_a.sym_ready, enable && (e_cnt[0] % 4 == 0));
         check("b_sym_ready", bus_b.sym_ready, enable && (e_cnt[1] % 4 == 0));
      end
      predict(0, va, sa);
      predict(1, 1'b1, sb);
      @(posedge clk);
      #2;
      if (rst) begin
         check("rst_y", $signed(bus_a.y), 0);
         check("rst_y_valid", bus_a.y_valid, 0);
         check("rst_underrun", bus_a.underrun, 0);
         check("rst_b_y", $signed(bus_b.y), 0);
      end else if (!en) begin
         check("stall_y", $signed(bus_a.y), last_y[0]);
         check("stall_y_valid", bus_a.y_valid, 0);
         check("stall_b_y", $signed(bus_b.y), last_y[1]);
      end
   endtask

   task automatic impulse(input logic [1:0] s, input logic [1:0] sb, input longint pk);
      int guard = 0;
      while ((e_cnt[0] % 4 != 0) && (guard < 8)) begin
         step(1'b0, 1'b1, 1'b0, 2'b00, sb);
         guard++;
      end
      step(1'b0, 1'b1, 1'b1, s, sb);
      for (int n = 0; n < 40; n++) begin
         step(1'b0, 1'b1, 1'b0, 2'b00, sb);
         y_hist[n] = bus_a.y;
      end
      check("imp_peak", y_hist[15], pk);
      check("imp_underrun", bus_a.underrun, 1);
   endtask

   initial begin
      int pulses;
      bus_a.sym_valid = 1'b0;
      bus_a.sym_in    = 2'b00;
      bus_b.sym_valid = 1'b0;
      bus_b.sym_in    = 2'b00;

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 2'b10);

      // Impulse of +3A: 24576*h[n]/65536 floored.
      impulse(2'b10, 2'b10, 9121);
      for (int n = 0; n < 7; n++) check("imp_zero_head", y_hist[n], 0);
      check("imp_n7", y_hist[7], 453);     // 24576*1208/65536 is exact
      check("imp_n14", y_hist[14], 8053);
      check("imp_n16", y_hist[16], 8053);
      check("imp_n23", y_hist[23], 453);
      for (int n = 31; n < 40; n++) check("imp_zero_tail", y_hist[n], 0);

      // Remaining Gray levels.
      impulse(2'b00, 2'b10, -9122);
      impulse(2'b01, 2'b10, -3041);
      impulse(2'b11, 2'b10, 3040);

      // Backpressure: valid held high, ready must pulse 1 in 4.
      step(1'b1, 1'b1, 1'b0, 2'b00, 2'b10);
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         step(1'b0, 1'b1, 1'b1, 2'($urandom), 2'b10);
         if (rdy_seen_a === 1'b1) pulses++;
      end
      check("bp_ready_pulses", pulses, 20);
      check("bp_underrun", bus_a.underrun, 0);

      // Enable stall mid-stream.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 2'($urandom), 2'b10);
      for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, 1'b1, 2'($urandom), 2'b10);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 2'($urandom), 2'b10);

      // Random valid and enable; dut_b switches to constant 00.
      for (int i = 0; i < 300; i++) begin
         step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 2'($urandom), 2'b00);
      end
      check("sat_hi_seen", (sat_hi > 0), 1);
      check("sat_lo_seen", (sat_lo > 0), 1);

      // Reset during a run of peak symbols, then three missed requests.
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 2'b10, 2'b10);
      step(1'b1, 1'b1, 1'b1, 2'b10, 2'b10);
      step(1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
      check("first_ready_after_reset", rdy_seen_a, 1);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
      check("missed_underrun", bus_a.underrun, 1);
`ifdef TX_SRRC_UNDERRUN_CNT_EN
      check("missed_underrun_cnt", cnt_a, 3);
`endif

      step(1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
      step(1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
      #3;
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
